// File: rtl/rtl_operand_pkg.sv
// Shared types and defaults for the operand skid buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: skid state enum, default-width operand pair struct, default
// WIDTH / CNT_WIDTH constants.
package rtl_operand_pkg;

   localparam int DEF_WIDTH     = 4;
   localparam int DEF_CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   // Default-width view of an operand pair; parameterised instances build
   // the same layout locally at their own WIDTH.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] in1;
      logic [DEF_WIDTH-1:0] in2;
   } operand_pair_t;

endpackage

// File: rtl/rtl_wrap_counter.sv
// Free-running event counter that wraps from all-ones back to zero.
// Latency: count reflects an inc one cycle after the edge that samples it.
// Backpressure: none; counts every cycle inc is high.
//
// Ports: CLK, RESET (sync, active-high), inc (count enable), count (value).
module rtl_wrap_counter #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/rtl_operand_skid.sv
// 2-entry ready/valid skid buffer for operand pairs feeding a downstream RTL block.
// Latency: 1 cycle from accept to handshake_valid when empty; 1 pair/cycle sustained.
// Backpressure: up_ready drops only when both entries are full; no comb path from handshake_ready.
//
// Ports: CLK, RESET (sync, active-high); upstream up_valid/up_ready/up_in1/up_in2;
// downstream handshake_valid/handshake_ready/in1/in2; occupancy (0..2);
// xfer_count (completed downstream transfers, wrapping).
// Optional: define RTL_OPERAND_SKID_ASSERT_EN to compile in protocol assertions.
module rtl_operand_skid
   import rtl_operand_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic [WIDTH-1:0]     up_in1,
   input  logic [WIDTH-1:0]     up_in2,
   output logic                 handshake_valid,
   input  logic                 handshake_ready,
   output logic [WIDTH-1:0]     in1,
   output logic [WIDTH-1:0]     in2,
   output logic [1:0]           occupancy,
   output logic [CNT_WIDTH-1:0] xfer_count
);

   typedef struct packed {
      logic [WIDTH-1:0] in1;
      logic [WIDTH-1:0] in2;
   } pair_t;

   skid_state_t state_q, state_d;
   pair_t       main_q,  main_d;
   pair_t       skid_q,  skid_d;
   pair_t       up_pair;
   logic        push;
   logic        pop;

   assign up_pair = '{in1: up_in1, in2: up_in2};

   // Ready depends only on the state register and reset, so a downstream
   // stall never ripples combinationally back upstream.
   assign up_ready        = (state_q != TWO) && !RESET;
   assign handshake_valid = (state_q != EMPTY);
   assign push            = up_valid && up_ready;
   assign pop             = handshake_valid && handshake_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               main_d  = up_pair;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               // Head leaves as the new pair arrives: refill head directly.
               main_d = up_pair;
            end else if (push) begin
               skid_d  = up_pair;
               state_d = TWO;
            end else if (pop) begin
               // Head keeps its value so in1/in2 hold while empty.
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign in1       = main_q.in1;
   assign in2       = main_q.in2;
   assign occupancy = state_q;

   // Reset takes priority inside the counter, so a pop during reset is not counted.
   rtl_wrap_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_xfer_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (pop),
      .count (xfer_count)
   );

`ifdef RTL_OPERAND_SKID_ASSERT_EN
   a_stall_stable: assert property (@(posedge CLK) disable iff (RESET)
      (handshake_valid && !handshake_ready) |=> ($stable(in1) && $stable(in2)));

   a_state_legal: assert property (@(posedge CLK) disable iff (RESET)
      (state_q == EMPTY) || (state_q == ONE) || (state_q == TWO));

   a_no_pop_empty: assert property (@(posedge CLK) disable iff (RESET)
      !((state_q == EMPTY) && pop));

   a_full_not_ready: assert property (@(posedge CLK) disable iff (RESET)
      (state_q == TWO) |-> !up_ready);
`else
`endif

endmodule

// File: tb/tb_rtl_operand_skid.sv
module tb_rtl_operand_skid;

   logic       CLK;
   logic       RESET;
   logic       up_valid;
   logic       up_ready;
   logic [3:0] up_in1;
   logic [3:0] up_in2;
   logic       handshake_valid;
   logic       handshake_ready;
   logic [3:0] in1;
   logic [3:0] in2;
   logic [1:0] occupancy;
   logic [7:0] xfer_count;

   int checks  = 0;
   int passed  = 0;
   int pop_cnt = 0;
   int pc0;
   logic [7:0] exp_q[$];

   rtl_operand_skid #(
      .WIDTH     (4),
      .CNT_WIDTH (8)
   ) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .up_valid        (up_valid),
      .up_ready        (up_ready),
      .up_in1          (up_in1),
      .up_in2          (up_in2),
      .handshake_valid (handshake_valid),
      .handshake_ready (handshake_ready),
      .in1             (in1),
      .in2             (in2),
      .occupancy       (occupancy),
      .xfer_count      (xfer_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Scoreboard feeder: every accepted pair is queued as the expected output.
   always @(negedge CLK) begin
      if (!RESET && up_valid && up_ready) exp_q.push_back({up_in1, up_in2});
   end

   // Monitor: every downstream transfer must match the oldest accepted pair.
   always @(negedge CLK) begin
      if (!RESET && handshake_valid && handshake_ready) begin
         pop_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pop: got %0h expected no transfer", {in1, in2});
         end else begin
            check("pop_order", {24'd0, in1, in2}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      RESET = 1'b1; up_valid = 1'b0; up_in1 = '0; up_in2 = '0; handshake_ready = 1'b0;
      repeat (2) step();
      @(negedge CLK);
      check("rst_up_ready", up_ready, 0);
      check("rst_valid", handshake_valid, 0);
      check("rst_occ", occupancy, 0);
      check("rst_in1", in1, 0);
      check("rst_in2", in2, 0);
      check("rst_xfer", xfer_count, 0);
      step();
      RESET = 1'b0;
      @(negedge CLK);
      check("post_rst_up_ready", up_ready, 1);

      // Single pair (3,5), popped the cycle it appears.
      step();
      up_valid = 1'b1; up_in1 = 4'd3; up_in2 = 4'd5; handshake_ready = 1'b1;
      step();
      up_valid = 1'b0;
      @(negedge CLK);
      check("t1_valid", handshake_valid, 1);
      check("t1_in1", in1, 3);
      check("t1_in2", in2, 5);
      check("t1_occ", occupancy, 1);
      step();
      @(negedge CLK);
      check("t1_xfer", xfer_count, 1);
      check("t1_empty_valid", handshake_valid, 0);
      check("t1_empty_hold_in1", in1, 3);
      check("t1_empty_hold_in2", in2, 5);

      // Stall: fill both entries, then release.
      step();
      handshake_ready = 1'b0;
      up_valid = 1'b1; up_in1 = 4'd1; up_in2 = 4'd2;
      step();
      up_in1 = 4'd4; up_in2 = 4'd8;
      step();
      up_valid = 1'b0;
      @(negedge CLK);
      check("t2_occ_full", occupancy, 2);
      check("t2_up_ready_full", up_ready, 0);
      check("t2_in_held", {in1, in2}, 8'h12);
      step();
      @(negedge CLK);
      check("t2_in_stall_stable", {in1, in2}, 8'h12);
      step();
      handshake_ready = 1'b1;
      @(negedge CLK);
      check("t2_first_out", {in1, in2}, 8'h12);
      step();
      @(negedge CLK);
      check("t2_second_out", {in1, in2}, 8'h48);
      check("t2_occ_one", occupancy, 1);
      step();
      @(negedge CLK);
      check("t2_occ_empty", occupancy, 0);
      check("t2_xfer", xfer_count, 3);

      // 16 back-to-back pairs (i, 15-i) with ready held high.
      step();
      pc0 = pop_cnt;
      for (int i = 0; i < 16; i++) begin
         up_valid = 1'b1; up_in1 = 4'(i); up_in2 = 4'(15 - i);
         @(negedge CLK);
         check("t3_occ", occupancy, (i == 0) ? 0 : 1);
         step();
      end
      up_valid = 1'b0;
      @(negedge CLK);
      check("t3_occ_tail", occupancy, 1);
      step();
      @(negedge CLK);
      check("t3_pops", pop_cnt - pc0, 16);
      check("t3_occ_done", occupancy, 0);
      check("t3_xfer", xfer_count, 19);

      // Reset while two pairs are buffered: they must never appear.
      step();
      handshake_ready = 1'b0;
      up_valid = 1'b1; up_in1 = 4'd9; up_in2 = 4'd6;
      step();
      up_in1 = 4'd10; up_in2 = 4'd5;
      step();
      up_valid = 1'b0;
      @(negedge CLK);
      check("t5_occ_full", occupancy, 2);
      step();
      RESET = 1'b1; up_valid = 1'b1; up_in1 = 4'd7; up_in2 = 4'd7; handshake_ready = 1'b1;
      exp_q.delete();
      @(negedge CLK);
      check("t5_up_ready_in_rst", up_ready, 0);
      step();
      RESET = 1'b0; up_valid = 1'b0;
      @(negedge CLK);
      check("t5_occ", occupancy, 0);
      check("t5_valid", handshake_valid, 0);
      check("t5_in", {in1, in2}, 8'h00);
      check("t5_xfer", xfer_count, 0);
      repeat (3) step();
      @(negedge CLK);
      check("t5_still_empty", handshake_valid, 0);

      // Counter wrap: 256 transfers return to 0, the 257th gives 1.
      step();
      handshake_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         up_valid = 1'b1; up_in1 = 4'(i); up_in2 = 4'(i >> 4);
         step();
      end
      up_valid = 1'b0;
      @(negedge CLK);
      check("t4_xfer_255", xfer_count, 255);
      step();
      @(negedge CLK);
      check("t4_xfer_wrap", xfer_count, 0);
      step();
      up_valid = 1'b1; up_in1 = 4'd1; up_in2 = 4'd1;
      step();
      up_valid = 1'b0;
      step();
      @(negedge CLK);
      check("t4_xfer_257", xfer_count, 1);

      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
